// File: rtl/sa_ctrl_pkg.sv
// Shared definitions for the systolic job arbiter: FSM states, default
// array geometry and the helper used to size flattened matrix buses.
package sa_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } sa_state_e;

  localparam int unsigned SA_ARRAY_SIZE      = 2;
  localparam int unsigned SA_DATA_WIDTH      = 16;
  localparam int unsigned SA_WEIGHT_WIDTH    = 8;
  localparam int unsigned SA_TIMEOUT_DEFAULT = 64;

  // Width of a square dim x dim matrix of w-bit elements, flattened.
  function automatic int unsigned mat_flat_w(input int unsigned dim, input int unsigned w);
    return dim * dim * w;
  endfunction

  localparam int unsigned SA_A_FLAT_W = mat_flat_w(SA_ARRAY_SIZE, SA_DATA_WIDTH);
  localparam int unsigned SA_B_FLAT_W = mat_flat_w(SA_ARRAY_SIZE, SA_WEIGHT_WIDTH);
  localparam int unsigned SA_R_FLAT_W = SA_A_FLAT_W;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request after last_grant_i,
// wrapping modulo NUM_REQ. Produces both one-hot and binary grant.
module rr_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  req_i,
  input  logic [ID_WIDTH-1:0] last_grant_i,
  output logic                any_o,
  output logic [NUM_REQ-1:0]  gnt_oh_o,
  output logic [ID_WIDTH-1:0] gnt_idx_o
);

  // Scan last_grant+1 .. last_grant+NUM_REQ and take the first hit.
  always_comb begin
    int unsigned idx;
    logic        found;
    idx       = 0;
    found     = 1'b0;
    any_o     = 1'b0;
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(last_grant_i) + k) % NUM_REQ;
      if (!found && req_i[idx]) begin
        found          = 1'b1;
        any_o          = 1'b1;
        gnt_oh_o[idx]  = 1'b1;
        gnt_idx_o      = ID_WIDTH'(idx);
      end
    end
  end

endmodule

// File: rtl/systolic_job_arbiter.sv
// Shares one systolic array between NUM_REQ requesters. Round-robin grant,
// operand latch, start pulse, done wait with watchdog, tagged response.
module systolic_job_arbiter
  import sa_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned ID_WIDTH       = 2,
  parameter int unsigned ARRAY_SIZE     = SA_ARRAY_SIZE,
  parameter int unsigned DATA_WIDTH     = SA_DATA_WIDTH,
  parameter int unsigned WEIGHT_WIDTH   = SA_WEIGHT_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = SA_TIMEOUT_DEFAULT
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic [NUM_REQ-1:0]                                req_valid,
  output logic [NUM_REQ-1:0]                                req_ready,
  input  logic [NUM_REQ*DATA_WIDTH*ARRAY_SIZE*ARRAY_SIZE-1:0]   req_a_flat,
  input  logic [NUM_REQ*WEIGHT_WIDTH*ARRAY_SIZE*ARRAY_SIZE-1:0] req_b_flat,
  output logic                                              rsp_valid,
  input  logic                                              rsp_ready,
  output logic [ID_WIDTH-1:0]                               rsp_id,
  output logic [DATA_WIDTH*ARRAY_SIZE*ARRAY_SIZE-1:0]       rsp_data,
  output logic                                              rsp_error,
  output logic                                              sa_start,
  output logic [DATA_WIDTH*ARRAY_SIZE*ARRAY_SIZE-1:0]       sa_matrix_a_flat,
  output logic [WEIGHT_WIDTH*ARRAY_SIZE*ARRAY_SIZE-1:0]     sa_matrix_b_flat,
  input  logic                                              sa_done,
  input  logic [DATA_WIDTH*ARRAY_SIZE*ARRAY_SIZE-1:0]       sa_result_flat,
  output logic                                              busy
);

  localparam int unsigned A_W = mat_flat_w(ARRAY_SIZE, DATA_WIDTH);
  localparam int unsigned B_W = mat_flat_w(ARRAY_SIZE, WEIGHT_WIDTH);
  localparam int unsigned R_W = A_W;
  localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  sa_state_e           state_q, state_d;
  logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
  logic [ID_WIDTH-1:0] grant_idx_q, grant_idx_d;
  logic [ID_WIDTH-1:0] last_grant_q, last_grant_d;
  logic [ID_WIDTH-1:0] job_id_q, job_id_d;
  logic [A_W-1:0]      a_q, a_d;
  logic [B_W-1:0]      b_q, b_d;
  logic                sa_start_q, sa_start_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [ID_WIDTH-1:0] rsp_id_q, rsp_id_d;
  logic [R_W-1:0]      rsp_data_q, rsp_data_d;
  logic                rsp_error_q, rsp_error_d;
  logic                busy_q, busy_d;

  logic                arb_any;
  logic [NUM_REQ-1:0]  arb_oh;
  logic [ID_WIDTH-1:0] arb_idx;

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_arb (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .any_o        (arb_any),
    .gnt_oh_o     (arb_oh),
    .gnt_idx_o    (arb_idx)
  );

  // Next-state and next-output logic; every output is produced from a register.
  always_comb begin
    state_d      = state_q;
    req_ready_d  = '0;
    grant_idx_d  = grant_idx_q;
    last_grant_d = last_grant_q;
    job_id_d     = job_id_q;
    a_d          = a_q;
    b_d          = b_q;
    sa_start_d   = 1'b0;
    timer_d      = timer_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_error_d  = rsp_error_q;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          req_ready_d = arb_oh;
          grant_idx_d = arb_idx;
          state_d     = ST_GRANT;
        end
      end
      ST_GRANT: begin
        a_d          = req_a_flat[32'(grant_idx_q) * A_W +: A_W];
        b_d          = req_b_flat[32'(grant_idx_q) * B_W +: B_W];
        job_id_d     = grant_idx_q;
        last_grant_d = grant_idx_q;
        sa_start_d   = 1'b1;
        state_d      = ST_ISSUE;
      end
      ST_ISSUE: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Done is checked first so it wins over a coincident timeout.
        if (sa_done) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = job_id_q;
          rsp_data_d  = sa_result_flat;
          rsp_error_d = 1'b0;
          state_d     = ST_RESP;
        end else if (timer_q == T_LAST) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = job_id_q;
          rsp_data_d  = '0;
          rsp_error_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= '0;
      grant_idx_q  <= '0;
      last_grant_q <= ID_WIDTH'(NUM_REQ - 1);
      job_id_q     <= '0;
      a_q          <= '0;
      b_q          <= '0;
      sa_start_q   <= 1'b0;
      timer_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
      rsp_error_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      grant_idx_q  <= grant_idx_d;
      last_grant_q <= last_grant_d;
      job_id_q     <= job_id_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sa_start_q   <= sa_start_d;
      timer_q      <= timer_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_error_q  <= rsp_error_d;
      busy_q       <= busy_d;
    end
  end

  assign req_ready        = req_ready_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_id           = rsp_id_q;
  assign rsp_data         = rsp_data_q;
  assign rsp_error        = rsp_error_q;
  assign sa_start         = sa_start_q;
  assign sa_matrix_a_flat = a_q;
  assign sa_matrix_b_flat = b_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_systolic_job_arbiter.sv
// Directed testbench for systolic_job_arbiter; the array is modelled by the
// bench driving sa_done / sa_result_flat at chosen cycles.
module tb_systolic_job_arbiter;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req_valid;
  logic [3:0]    req_ready;
  logic [255:0]  req_a_flat;
  logic [127:0]  req_b_flat;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_id;
  logic [63:0]   rsp_data;
  logic          rsp_error;
  logic          sa_start;
  logic [63:0]   sa_matrix_a_flat;
  logic [31:0]   sa_matrix_b_flat;
  logic          sa_done;
  logic [63:0]   sa_result_flat;
  logic          busy;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] A_ID = 64'h0400_0000_0000_0400;
  localparam logic [31:0] B_ID = 32'h4000_0040;

  always #5 clk = ~clk;

  systolic_job_arbiter #(
    .NUM_REQ        (4),
    .ID_WIDTH       (2),
    .ARRAY_SIZE     (2),
    .DATA_WIDTH     (16),
    .WEIGHT_WIDTH   (8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_a_flat       (req_a_flat),
    .req_b_flat       (req_b_flat),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_id           (rsp_id),
    .rsp_data         (rsp_data),
    .rsp_error        (rsp_error),
    .sa_start         (sa_start),
    .sa_matrix_a_flat (sa_matrix_a_flat),
    .sa_matrix_b_flat (sa_matrix_b_flat),
    .sa_done          (sa_done),
    .sa_result_flat   (sa_result_flat),
    .busy             (busy)
  );

  task automatic wait_grant(output logic [3:0] g);
    g = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready != 4'b0000) begin
        g = req_ready;
        break;
      end
    end
  endtask

  // Waits for sa_start, then pulses sa_done after delay cycles; ok=rsp_valid seen.
  task automatic serve_job(input int delay, input logic [63:0] res, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sa_start) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      sa_result_flat = res;
      repeat (delay) @(negedge clk);
      sa_done = 1'b1;
      @(negedge clk);
      sa_done = 1'b0;
      ok = (rsp_valid === 1'b1);
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++;
    if ({busy, sa_start, rsp_valid, rsp_error, req_ready} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000000", {busy, sa_start, rsp_valid, rsp_error, req_ready});
    end
    checks++;
    if ({rsp_id, rsp_data, sa_matrix_a_flat, sa_matrix_b_flat} !== '0) begin
      errors++;
      $display("FAIL reset_data: got id=%h data=%h a=%h b=%h expected all zero", rsp_id, rsp_data, sa_matrix_a_flat, sa_matrix_b_flat);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b ready=%b expected 0 0000", busy, req_ready);
    end
  endtask

  task automatic test_single_job();
    logic [3:0] g;
    req_valid = 4'b0100;
    wait_grant(g);
    req_valid = 4'b0000;
    checks++;
    if (g !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b expected 0100", g); end
    @(negedge clk);
    checks++;
    if (sa_start !== 1'b1 || sa_matrix_a_flat !== A_ID || sa_matrix_b_flat !== B_ID) begin
      errors++;
      $display("FAIL single_issue: got start=%b a=%h b=%h expected 1 %h %h", sa_start, sa_matrix_a_flat, sa_matrix_b_flat, A_ID, B_ID);
    end
    @(negedge clk);
    checks++;
    if (sa_start !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_wait: got start=%b busy=%b expected 0 1", sa_start, busy);
    end
    sa_result_flat = 64'h0400_0000_0000_0400;
    sa_done = 1'b1;
    @(negedge clk);
    sa_done = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_error !== 1'b0 || rsp_data !== 64'h0400_0000_0000_0400) begin
      errors++;
      $display("FAIL single_rsp: got v=%b id=%0d err=%b data=%h expected 1 2 0 0400000000000400", rsp_valid, rsp_id, rsp_error, rsp_data);
    end
    handshake();
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done: got v=%b busy=%b expected 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] g;
    logic [3:0] exp_g;
    bit ok;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req_valid = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      exp_g = 4'b0001 << (j % 4);
      wait_grant(g);
      checks++;
      if (g !== exp_g) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", j, g, exp_g); end
      serve_job(5, 64'h100 + 64'(j), ok);
      checks++;
      if (!ok || rsp_id !== 2'(j % 4) || rsp_data !== 64'h100 + 64'(j)) begin
        errors++;
        $display("FAIL rr_rsp%0d: got v=%b id=%0d data=%h expected 1 %0d %h", j, rsp_valid, rsp_id, rsp_data, j % 4, 64'h100 + 64'(j));
      end
      handshake();
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_back_to_back_backpressure();
    logic [3:0] g;
    bit ok;
    req_valid = 4'b0010;
    wait_grant(g);
    req_valid = 4'b0000;
    checks++;
    if (g !== 4'b0010) begin errors++; $display("FAIL bp_grant: got %b expected 0010", g); end
    serve_job(2, 64'hDEAD_BEEF_1234_5678, ok);
    req_valid = 4'b1000;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (!ok || rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 64'hDEAD_BEEF_1234_5678 || req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL bp_hold%0d: got v=%b id=%0d data=%h ready=%b expected 1 1 deadbeef12345678 0000", i, rsp_valid, rsp_id, rsp_data, req_ready);
      end
      @(negedge clk);
    end
    handshake();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL bp_after_hs: got v=%b ready=%b expected 0 0000", rsp_valid, req_ready);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_next_grant: got %b expected 1000", req_ready); end
    req_valid = 4'b0000;
    serve_job(1, 64'h3333, ok);
    checks++;
    if (!ok || rsp_id !== 2'd3) begin errors++; $display("FAIL bp_next_rsp: got v=%b id=%0d expected 1 3", rsp_valid, rsp_id); end
    handshake();
  endtask

  task automatic test_watchdog();
    logic [3:0] g;
    bit ok;
    bit seen;
    int cnt;
    req_valid = 4'b0001;
    wait_grant(g);
    req_valid = 4'b0000;
    checks++;
    if (g !== 4'b0001) begin errors++; $display("FAIL wd_grant: got %b expected 0001", g); end
    sa_result_flat = 64'hFFFF_FFFF_FFFF_FFFF;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sa_start) begin seen = 1'b1; break; end
    end
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cnt++;
      if (rsp_valid) break;
    end
    checks++;
    if (!seen || cnt != 17) begin errors++; $display("FAIL wd_latency: got start=%b cycles=%0d expected 1 17", seen, cnt); end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || rsp_data !== 64'h0 || rsp_id !== 2'd0) begin
      errors++;
      $display("FAIL wd_rsp: got v=%b err=%b data=%h id=%0d expected 1 1 0 0", rsp_valid, rsp_error, rsp_data, rsp_id);
    end
    handshake();
    req_valid = 4'b0010;
    wait_grant(g);
    req_valid = 4'b0000;
    checks++;
    if (g !== 4'b0010) begin errors++; $display("FAIL wd_next_grant: got %b expected 0010", g); end
    serve_job(3, 64'h0123_4567_89AB_CDEF, ok);
    checks++;
    if (!ok || rsp_error !== 1'b0 || rsp_id !== 2'd1 || rsp_data !== 64'h0123_4567_89AB_CDEF) begin
      errors++;
      $display("FAIL wd_next_rsp: got v=%b err=%b id=%0d data=%h expected 1 0 1 0123456789abcdef", rsp_valid, rsp_error, rsp_id, rsp_data);
    end
    handshake();
  endtask

  task automatic test_reset_mid_wait();
    logic [3:0] g;
    bit ok;
    req_valid = 4'b0100;
    wait_grant(g);
    req_valid = 4'b0000;
    checks++;
    if (g !== 4'b0100) begin errors++; $display("FAIL rmw_grant: got %b expected 0100", g); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sa_start) break;
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, sa_start, rsp_valid, rsp_error, req_ready, rsp_id} !== 10'h000 ||
        {rsp_data, sa_matrix_a_flat, sa_matrix_b_flat} !== '0) begin
      errors++;
      $display("FAIL rmw_async: got busy=%b start=%b v=%b a=%h expected all zero", busy, sa_start, rsp_valid, sa_matrix_a_flat);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rmw_no_rsp%0d: got v=%b busy=%b expected 0 0", i, rsp_valid, busy);
      end
    end
    req_valid = 4'b1001;
    wait_grant(g);
    req_valid = 4'b1000;
    checks++;
    if (g !== 4'b0001) begin errors++; $display("FAIL rmw_prio: got %b expected 0001", g); end
    serve_job(2, 64'h7, ok);
    handshake();
    wait_grant(g);
    req_valid = 4'b0000;
    checks++;
    if (g !== 4'b1000) begin errors++; $display("FAIL rmw_fair: got %b expected 1000", g); end
    serve_job(2, 64'h8, ok);
    checks++;
    if (!ok || rsp_id !== 2'd3) begin errors++; $display("FAIL rmw_fair_rsp: got v=%b id=%0d expected 1 3", rsp_valid, rsp_id); end
    handshake();
  endtask

  task automatic test_stale_done();
    logic [3:0] g;
    bit ok;
    sa_done = 1'b1;
    @(negedge clk);
    sa_done = 1'b0;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL stale_idle: got busy=%b v=%b ready=%b expected 0 0 0000", busy, rsp_valid, req_ready);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL stale_idle2: got busy=%b v=%b expected 0 0", busy, rsp_valid);
    end
    req_valid = 4'b0001;
    wait_grant(g);
    req_valid = 4'b0000;
    checks++;
    if (g !== 4'b0001) begin errors++; $display("FAIL stale_grant: got %b expected 0001", g); end
    serve_job(2, 64'hAAAA_AAAA_AAAA_AAAA, ok);
    sa_result_flat = 64'h5555_5555_5555_5555;
    sa_done = 1'b1;
    @(negedge clk);
    sa_done = 1'b0;
    checks++;
    if (!ok || rsp_valid !== 1'b1 || busy !== 1'b1 || rsp_data !== 64'hAAAA_AAAA_AAAA_AAAA) begin
      errors++;
      $display("FAIL stale_resp: got v=%b busy=%b data=%h expected 1 1 aaaaaaaaaaaaaaaa", rsp_valid, busy, rsp_data);
    end
    handshake();
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL stale_resp_hs: got %b expected 0", rsp_valid); end
    req_valid = 4'b0010;
    wait_grant(g);
    req_valid = 4'b0000;
    checks++;
    if (g !== 4'b0010) begin errors++; $display("FAIL coinc_grant: got %b expected 0010", g); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sa_start) break;
    end
    sa_result_flat = 64'h0BAD_CAFE_0000_1111;
    repeat (16) @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL coinc_early: got v=%b expected 0", rsp_valid); end
    sa_done = 1'b1;
    @(negedge clk);
    sa_done = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_id !== 2'd1 || rsp_data !== 64'h0BAD_CAFE_0000_1111) begin
      errors++;
      $display("FAIL coinc_rsp: got v=%b err=%b id=%0d data=%h expected 1 0 1 0badcafe00001111", rsp_valid, rsp_error, rsp_id, rsp_data);
    end
    handshake();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst            = 1'b1;
    req_valid      = '0;
    rsp_ready      = 1'b0;
    sa_done        = 1'b0;
    sa_result_flat = '0;
    for (int i = 0; i < 4; i++) begin
      req_a_flat[i*64 +: 64] = 64'h1000_2000_3000_4000 + 64'(i);
      req_b_flat[i*32 +: 32] = 32'h1020_3040 + 32'(i);
    end
    req_a_flat[2*64 +: 64] = A_ID;
    req_b_flat[2*32 +: 32] = B_ID;

    test_reset();
    test_single_job();
    test_round_robin();
    test_back_to_back_backpressure();
    test_watchdog();
    test_reset_mid_wait();
    test_stale_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_job_arbiter.md
Name: systolic_job_arbiter

Overview:
- Shares one systolic_array_top instance (2x2, 16-bit A, 8-bit B, 16-bit results) between NUM_REQ independent requesters.
- Round-robin arbitration; latches the winner's operands and pulses the array start.
- Waits for the array's done, then returns the result tagged with the requester id.
- A watchdog aborts jobs whose done never arrives, so one stuck job cannot hang the shared array.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_WIDTH, 2, width of requester id; must satisfy 2**ID_WIDTH >= NUM_REQ
ARRAY_SIZE, 2, systolic array dimension
DATA_WIDTH, 16, A-element and result-element width
WEIGHT_WIDTH, 8, B-element width
TIMEOUT_CYCLES, 64, maximum WAIT-state cycles before abort (>=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester job request; must stay high until its req_ready
req_ready  out  NUM_REQ  one-hot grant/accept strobe, registered
req_a_flat  in  NUM_REQ*DATA_WIDTH*ARRAY_SIZE**2  A matrices; requester i occupies slice i
req_b_flat  in  NUM_REQ*WEIGHT_WIDTH*ARRAY_SIZE**2  B matrices; requester i occupies slice i
rsp_valid  out  1  response available
rsp_ready  in  1  response consumer accept
rsp_id  out  ID_WIDTH  requester id of the response
rsp_data  out  DATA_WIDTH*ARRAY_SIZE**2  result matrix, same flat layout as the array output
rsp_error  out  1  job aborted by watchdog; rsp_data is zero
sa_start  out  1  one-cycle start pulse to the array
sa_matrix_a_flat  out  DATA_WIDTH*ARRAY_SIZE**2  latched A operands to the array
sa_matrix_b_flat  out  WEIGHT_WIDTH*ARRAY_SIZE**2  latched B operands to the array
sa_done  in  1  array completion
sa_result_flat  in  DATA_WIDTH*ARRAY_SIZE**2  array result
busy  out  1  high in every state except IDLE

Behaviour:
- All outputs are registered.
- Reset (async, any state):
  - State IDLE.
  - All outputs 0, including operands, rsp_data and rsp_id.
  - Timer 0.
  - last_grant = NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-job drops the job silently; no response is issued.
- IDLE:
  - If any req_valid, winner = first asserted index scanning last_grant+1 upward, wrapping modulo NUM_REQ.
  - Register the one-hot winner into req_ready; go GRANT.
  - With no request pending, stay in IDLE.
- GRANT (1 cycle):
  - req_ready[winner]=1; the handshake completes this cycle.
  - Latch the winner's A/B slices into sa_matrix_*_flat and the winner index into the job id.
  - last_grant <= winner; clear req_ready; go ISSUE.
  - req_valid dropping before grant is a requester protocol violation; the controller still latches the inputs.
- ISSUE (1 cycle): sa_start=1, timer cleared; go WAIT.
  - Operands stay stable from GRANT until the job leaves WAIT.
- WAIT:
  - sa_start=0; timer increments each cycle.
  - sa_done=1: capture sa_result_flat into rsp_data, rsp_error=0, go RESP.
  - Timeout, when timer reaches TIMEOUT_CYCLES-1 without done: rsp_data=0, rsp_error=1, go RESP.
  - If done and timeout occur in the same cycle, done wins.
- RESP:
  - rsp_valid=1 with rsp_id/rsp_data/rsp_error held stable until rsp_valid&&rsp_ready.
  - On that handshake: rsp_valid<=0, go IDLE.
  - A new request is not sampled in the same cycle; minimum job spacing is IDLE->GRANT->ISSUE->WAIT(>=1)->RESP(>=1).
- sa_done in IDLE, GRANT, ISSUE or RESP is stale and ignored.
- Latency: req_valid rising in IDLE -> req_ready +1 -> sa_start +2 -> rsp_valid 1 cycle after sa_done.
- Requests arriving while busy wait; no queueing beyond the requesters' own valid holding.
- Fairness: a continuously requesting requester is served within NUM_REQ jobs.

Decomposition:
- Shared package sa_ctrl_pkg holds:
  - state encoding (IDLE, GRANT, ISSUE, WAIT, RESP);
  - matrix flat-width localparams derived from ARRAY_SIZE/DATA_WIDTH/WEIGHT_WIDTH;
  - TIMEOUT default.
- One sub-module, rr_arbiter: combinational round-robin pick of the first set bit after last_grant, with wrap. The FSM, timer and latches stay in the top module.

Test Plan:
1. Single job, real systolic_array_top, requester 2: A=0x0400000000000400, B=0x40000040 (identity, 1.0 at [0][0]/[1][1]) -> one sa_start pulse, rsp_valid with rsp_id=2, rsp_error=0, rsp_data identity in result format, i.e. [15:0] and [63:48] = 1.0, others 0.
2. Round robin, behavioural array stub with done 5 cycles after start: all four req_valid held high -> grant order 0,1,2,3,0; each rsp_id matches its grant order; exactly one req_ready bit high per job.
3. Backpressure: rsp_ready low for 10 cycles in RESP -> rsp_valid, rsp_id and rsp_data stable all 10 cycles; no new req_ready until the cycle after the handshake.
4. Watchdog, TIMEOUT_CYCLES=16, stub never asserts done -> rsp_error=1, rsp_data=0, rsp_valid exactly 16 cycles after leaving ISSUE; next job proceeds normally.
5. Reset mid-WAIT: assert rst for 1 cycle between clock edges -> all outputs 0 immediately, no rsp_valid for the aborted job; after release, requester 0 wins when 0 and 3 both request.
6. Stale done: pulse sa_done while in IDLE and in RESP -> no state change, no spurious rsp_valid; done coincident with the timeout cycle -> rsp_error=0 with the captured result.
